wb_dec_n: RTL and testbench
===========================

Name: wb_dec_n

Overview:
Parametrised successor to the fixed four-way Wishbone address decoder.
- Routes one master (the request-to-Wishbone bridge output) to N_SLV slaves, using a per-slave base/mask table held in parameters.
- Registers strobe and response paths and tracks exactly one outstanding cycle.
- Adds what the fixed decoder lacks: an unmapped-address bus error, a per-access watchdog timeout, and sticky fault capture for firmware diagnosis.

Parameters:
- N_SLV, 4, number of slave ports (1..16).
- AW, 30, word-address width.
- DW, 32, data width.
- BASE, {N_SLV{AW'h0}}, packed per-slave base addresses; slave i occupies bits [i*AW +: AW].
- MASK, {N_SLV{AW'h0}}, packed per-slave compare masks (1 = bit compared).
- TIMEOUT, 255, cycles to wait for a slave ack; 0 disables the watchdog.
- ERR_DATA, 32'hFFFF_FFFF, value driven on dat_o with err_o.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-low reset.
- cyc_i  in  1  master cycle.
- stb_i  in  1  master strobe.
- adr_i  in  AW  master word address.
- ack_o  out  1  registered ack, one-cycle pulse.
- err_o  out  1  registered bus error, one-cycle pulse.
- dat_o  out  DW  registered read data.
- slv_stb_o  out  N_SLV  one-hot slave strobes.
- slv_ack_i  in  N_SLV  slave acks.
- slv_dat_i  in  N_SLV*DW  packed slave read data.
- fault_valid_o  out  1  sticky: an error has occurred.
- fault_adr_o  out  AW  address of the first error.
- fault_type_o  out  1  0 = unmapped, 1 = timeout.
- fault_clr_i  in  1  clears the fault registers.

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE; ack_o, err_o, slv_stb_o, fault_valid_o, fault_type_o = 0; dat_o, fault_adr_o = 0; watchdog counter = 0.
- Address match: hit[i] = ((adr_i ^ BASE_i) & MASK_i) == 0. Lowest index wins when several match. The match vector is computed combinationally and sampled only in IDLE.
- IDLE: on cyc_i & stb_i:
  - any hit: latch sel and adr, set slv_stb_o[sel] = 1 at the next edge, go to ACTIVE.
  - no hit: go to RESP with err_o = 1 and dat_o = ERR_DATA at the next edge; record an unmapped fault.
- ACTIVE: slv_stb_o[sel] held high while waiting; the watchdog increments every cycle.
  - slv_ack_i[sel] = 1: at the next edge slv_stb_o = 0, ack_o = 1, dat_o = slv_dat_i[sel], go to RESP.
  - Acks on non-selected slaves are ignored.
  - TIMEOUT != 0 and counter reaches TIMEOUT-1 with no ack: at the next edge slv_stb_o = 0, err_o = 1, dat_o = ERR_DATA, record a timeout fault, go to RESP.
  - Ack and timeout in the same cycle: ack wins.
  - cyc_i = 0 (master abort): at the next edge slv_stb_o = 0, go to IDLE, no ack or err. A late slave ack in IDLE is ignored.
- RESP: ack_o or err_o is high for exactly this cycle; stb_i is ignored. Next state is IDLE. The watchdog clears on leaving ACTIVE.
- Minimum latency: stb_i sampled at edge 0, slv_stb at edge 1, zero-wait slave acks in that cycle, ack_o at edge 2. An unmapped access gives err_o at edge 1.
- Back-to-back: a new request may be accepted in the first IDLE cycle after RESP.
- Fault capture:
  - Records only when fault_valid_o = 0, so the first fault is kept.
  - fault_clr_i = 1 clears fault_valid_o.
  - A fault arriving in the same cycle as fault_clr_i is recorded; set beats clear.
- Watchdog counter width is clog2(TIMEOUT+1); it saturates and never wraps.
- dat_o holds its value between responses.

Decomposition:
- Shared package wb_pkg:
  - FSM state enum (IDLE, ACTIVE, RESP).
  - fault type constants FAULT_UNMAPPED = 0, FAULT_TIMEOUT = 1.
  - default ERR_DATA.
- Natural sub-module: wb_watchdog, a parametrised saturating timeout counter with clear/enable inputs and an expired output. It is reused later for cpuif bus timeouts.

Test Plan:
- N_SLV = 4, BASE = {0x300, 0x200, 0x100, 0x000}, MASK = 0x3FFF_FF00, zero-wait slave 1 returning 0xDEADBEEF; read adr 0x105 -> slv_stb_o = 4'b0010 at edge 1, ack_o at edge 2 with dat_o = 0xDEADBEEF, ack_o high for one cycle only.
- Read adr 0x3F0_0000 (no match) -> err_o at edge 1, dat_o = 0xFFFFFFFF; fault_valid_o = 1, fault_type_o = 0, fault_adr_o = 0x3F0_0000; no slv_stb_o asserted.
- TIMEOUT = 16, slave 2 never acks -> slv_stb_o[2] high for 16 cycles, then err_o with fault_type_o = 1. A second timeout does not overwrite fault_adr_o; fault_clr_i then clears fault_valid_o.
- Slave 0 acks after 5 wait states with TIMEOUT = 6 (ack and expiry in the same cycle) -> ack_o, not err_o; no fault recorded.
- cyc_i dropped after 3 cycles in ACTIVE -> slv_stb_o = 0 next edge, no ack_o/err_o; a slave ack arriving one cycle later is ignored. The next request is serviced normally.
- rst_i pulsed low mid-ACTIVE, asynchronous to the clock -> slv_stb_o, ack_o and err_o drop immediately, fault registers cleared, state IDLE after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone decoder family: FSM states,
// fault type encodings and the default error read-data pattern.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } wb_state_e;

    localparam logic FAULT_UNMAPPED = 1'b0;
    localparam logic FAULT_TIMEOUT  = 1'b1;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/wb_watchdog.sv
// Saturating cycle counter that flags when a wait has lasted TIMEOUT
// cycles. TIMEOUT = 0 disables the expiry output entirely.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] SAT  = (TIMEOUT > 0) ? CW'(TIMEOUT) : '0;

    logic [CW-1:0] cnt_r;

    // Count enabled cycles, stop at the saturation value, clear on request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != SAT)) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (TIMEOUT != 0) && (cnt_r == LAST);

endmodule

// File: rtl/wb_dec_n.sv
// N-way Wishbone address decoder with one outstanding cycle, registered
// strobes/responses, unmapped-address error, ack watchdog and sticky
// first-fault capture.
module wb_dec_n
    import wb_pkg::*;
#(
    parameter int                      N_SLV    = 4,
    parameter int                      AW       = 30,
    parameter int                      DW       = 32,
    parameter logic [N_SLV*AW-1:0]     BASE     = '0,
    parameter logic [N_SLV*AW-1:0]     MASK     = '0,
    parameter int                      TIMEOUT  = 255,
    parameter logic [DW-1:0]           ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic [AW-1:0]         adr_i,
    output logic                  ack_o,
    output logic                  err_o,
    output logic [DW-1:0]         dat_o,
    output logic [N_SLV-1:0]      slv_stb_o,
    input  logic [N_SLV-1:0]      slv_ack_i,
    input  logic [N_SLV*DW-1:0]   slv_dat_i,
    output logic                  fault_valid_o,
    output logic [AW-1:0]         fault_adr_o,
    output logic                  fault_type_o,
    input  logic                  fault_clr_i
);

    localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;

    wb_state_e        state_r, state_nxt;
    logic [SW-1:0]    sel_r, sel_nxt, hit_idx_s;
    logic [AW-1:0]    adr_r, adr_nxt;
    logic [N_SLV-1:0] stb_r, stb_nxt;
    logic             ack_r, ack_nxt, err_r, err_nxt;
    logic [DW-1:0]    dat_r, dat_nxt;
    logic             fv_r, fv_nxt, ft_r, ft_nxt;
    logic [AW-1:0]    fa_r, fa_nxt;
    logic             any_hit_s, req_s, sel_ack_s, expired_s;
    logic             fault_set_s, fault_type_s;
    logic [AW-1:0]    fault_adr_s;
    logic [DW-1:0]    sel_dat_s;

    assign req_s     = cyc_i & stb_i;
    assign sel_ack_s = slv_ack_i[sel_r];
    assign sel_dat_s = slv_dat_i[sel_r*DW +: DW];

    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .clr     (state_r != ST_ACTIVE),
        .en      (state_r == ST_ACTIVE),
        .expired (expired_s)
    );

    // Address decode: scan downwards so the lowest matching slave wins
    always_comb begin
        any_hit_s = 1'b0;
        hit_idx_s = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (((adr_i ^ BASE[i*AW +: AW]) & MASK[i*AW +: AW]) == '0) begin
                any_hit_s = 1'b1;
                hit_idx_s = SW'(i);
            end else begin
                any_hit_s = any_hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic; a master abort takes priority over a late ack or expiry
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nxt = any_hit_s ? ST_ACTIVE : ST_RESP;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (!cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (sel_ack_s || expired_s) begin
                    state_nxt = ST_RESP;
                end else begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and fault capture; ack beats expiry
    always_comb begin
        stb_nxt      = '0;
        ack_nxt      = 1'b0;
        err_nxt      = 1'b0;
        dat_nxt      = dat_r;
        sel_nxt      = sel_r;
        adr_nxt      = adr_r;
        fault_set_s  = 1'b0;
        fault_type_s = FAULT_UNMAPPED;
        fault_adr_s  = adr_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s && any_hit_s) begin
                    sel_nxt            = hit_idx_s;
                    adr_nxt            = adr_i;
                    stb_nxt[hit_idx_s] = 1'b1;
                end else if (req_s) begin
                    err_nxt      = 1'b1;
                    dat_nxt      = ERR_DATA;
                    fault_set_s  = 1'b1;
                    fault_adr_s  = adr_i;
                    fault_type_s = FAULT_UNMAPPED;
                end else begin
                    stb_nxt = '0;
                end
            end
            ST_ACTIVE: begin
                if (!cyc_i) begin
                    stb_nxt = '0;
                end else if (sel_ack_s) begin
                    ack_nxt = 1'b1;
                    dat_nxt = sel_dat_s;
                end else if (expired_s) begin
                    err_nxt      = 1'b1;
                    dat_nxt      = ERR_DATA;
                    fault_set_s  = 1'b1;
                    fault_adr_s  = adr_r;
                    fault_type_s = FAULT_TIMEOUT;
                end else begin
                    stb_nxt = stb_r;
                end
            end
            ST_RESP: stb_nxt = '0;
            default: stb_nxt = '0;
        endcase

        fv_nxt = fv_r;
        fa_nxt = fa_r;
        ft_nxt = ft_r;
        if (fault_set_s && (!fv_r || fault_clr_i)) begin
            fv_nxt = 1'b1;
            fa_nxt = fault_adr_s;
            ft_nxt = fault_type_s;
        end else if (fault_clr_i) begin
            fv_nxt = 1'b0;
        end else begin
            fv_nxt = fv_r;
        end
    end

    // Output, selection and fault registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stb_r <= '0;
            ack_r <= 1'b0;
            err_r <= 1'b0;
            dat_r <= '0;
            sel_r <= '0;
            adr_r <= '0;
            fv_r  <= 1'b0;
            fa_r  <= '0;
            ft_r  <= 1'b0;
        end else begin
            stb_r <= stb_nxt;
            ack_r <= ack_nxt;
            err_r <= err_nxt;
            dat_r <= dat_nxt;
            sel_r <= sel_nxt;
            adr_r <= adr_nxt;
            fv_r  <= fv_nxt;
            fa_r  <= fa_nxt;
            ft_r  <= ft_nxt;
        end
    end

    assign slv_stb_o     = stb_r;
    assign ack_o         = ack_r;
    assign err_o         = err_r;
    assign dat_o         = dat_r;
    assign fault_valid_o = fv_r;
    assign fault_adr_o   = fa_r;
    assign fault_type_o  = ft_r;

endmodule

// File: tb/tb_wb_dec_n.sv
// Self-checking bench for wb_dec_n: directed boundary cases plus random
// transactions against a transaction-level reference model.
module tb_wb_dec_n;

    localparam int TMO   = 16;
    localparam int NEVER = 1000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cyc = 1'b0;
    logic         stb = 1'b0;
    logic [29:0]  adr = 30'h0;
    logic         ack_o, err_o;
    logic [31:0]  dat_o;
    logic [3:0]   slv_stb;
    logic [3:0]   slv_ack;
    logic [127:0] slv_dat;
    logic         fault_valid, fault_type;
    logic [29:0]  fault_adr;
    logic         fault_clr = 1'b0;

    int           checks = 0;
    int           errors = 0;

    // slave models: ack after slv_wait wait states, plus forced stray acks
    int           slv_wait[4] = '{default: 0};
    int           slv_cnt[4]  = '{default: 0};
    logic [31:0]  slv_data[4] = '{default: 32'h0};
    logic [3:0]   late_ack    = 4'h0;
    logic [29:0]  base_tab[4] = '{30'h000, 30'h100, 30'h200, 30'h300};
    logic [29:0]  mask_val    = 30'h3FFF_FF00;

    // reference fault state
    bit           mf_valid = 1'b0;
    logic [29:0]  mf_adr   = 30'h0;
    logic         mf_type  = 1'b0;

    wb_dec_n #(
        .N_SLV   (4),
        .AW      (30),
        .DW      (32),
        .BASE    ({30'h300, 30'h200, 30'h100, 30'h000}),
        .MASK    ({4{30'h3FFF_FF00}}),
        .TIMEOUT (TMO),
        .ERR_DATA(32'hFFFF_FFFF)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cyc_i        (cyc),
        .stb_i        (stb),
        .adr_i        (adr),
        .ack_o        (ack_o),
        .err_o        (err_o),
        .dat_o        (dat_o),
        .slv_stb_o    (slv_stb),
        .slv_ack_i    (slv_ack),
        .slv_dat_i    (slv_dat),
        .fault_valid_o(fault_valid),
        .fault_adr_o  (fault_adr),
        .fault_type_o (fault_type),
        .fault_clr_i  (fault_clr)
    );

    always #5 clk = ~clk;

    // count cycles each slave has seen its strobe
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) slv_cnt[i] <= slv_stb[i] ? slv_cnt[i] + 1 : 0;
    end

    // slave ack and read data
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slv_ack[i] = (slv_stb[i] && (slv_cnt[i] == slv_wait[i])) || late_ack[i];
            slv_dat[i*32 +: 32] = slv_data[i];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_faults();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        mf_valid  = 1'b0;
        chk("fault_clr", fault_valid, 1'b0);
    endtask

    // one complete master transaction checked against the model
    task automatic run_req(input logic [29:0] a);
        int   idx, dur, lat, n, stb_n;
        bit   exp_ack, stb_bad, done;
        logic [3:0]  exp_stb;
        logic [31:0] exp_dat;
        idx = -1;
        for (int i = 3; i >= 0; i--)
            if (((a ^ base_tab[i]) & mask_val) == 30'h0) idx = i;
        if (idx < 0) begin
            lat = 1; dur = 0; exp_ack = 1'b0; exp_stb = 4'h0; exp_dat = 32'hFFFF_FFFF;
        end else begin
            exp_ack = (slv_wait[idx] + 1) <= TMO;
            dur     = exp_ack ? slv_wait[idx] + 1 : TMO;
            lat     = dur + 1;
            exp_stb = 4'b0001 << idx;
            exp_dat = exp_ack ? slv_data[idx] : 32'hFFFF_FFFF;
        end
        if (!exp_ack && !mf_valid) begin
            mf_valid = 1'b1;
            mf_adr   = a;
            mf_type  = (idx < 0) ? 1'b0 : 1'b1;
        end
        cyc = 1'b1; stb = 1'b1; adr = a;
        n = 0; stb_n = 0; stb_bad = 1'b0; done = 1'b0;
        while (!done && n < 100) begin
            tick();
            n++;
            if (slv_stb != 4'h0) begin
                stb_n++;
                if (slv_stb !== exp_stb) stb_bad = 1'b1;
            end
            if (ack_o || err_o) done = 1'b1;
        end
        cyc = 1'b0; stb = 1'b0;
        chk("latency", n, lat);
        chk("ack", ack_o, exp_ack);
        chk("err", err_o, !exp_ack);
        chk("dat", dat_o, exp_dat);
        chk("stb_cycles", stb_n, dur);
        chk("stb_onehot", stb_bad, 1'b0);
        chk("fault_valid", fault_valid, mf_valid);
        if (mf_valid) begin
            chk("fault_adr", fault_adr, mf_adr);
            chk("fault_type", fault_type, mf_type);
        end
        tick();
        chk("resp_pulse", {ack_o, err_o}, 2'b00);
    endtask

    initial begin
        logic [29:0] a;
        tick();
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_stb", slv_stb, 4'h0);
        chk("rst_dat", dat_o, 32'h0);
        chk("rst_fv", fault_valid, 1'b0);
        chk("rst_fadr", fault_adr, 30'h0);
        chk("rst_ftype", fault_type, 1'b0);
        rst = 1'b1;
        tick();

        // zero-wait read of slave 1
        slv_wait[1] = 0; slv_data[1] = 32'hDEAD_BEEF;
        run_req(30'h105);

        // unmapped access
        run_req(30'h3F0_0000);

        // two timeouts: first fault is kept, then cleared
        clear_faults();
        slv_wait[2] = NEVER;
        run_req(30'h210);
        run_req(30'h220);
        clear_faults();

        // ack on the same cycle the watchdog expires
        slv_wait[0] = TMO - 1; slv_data[0] = 32'h1234_5678;
        run_req(30'h044);
        slv_wait[0] = TMO;
        run_req(30'h045);
        clear_faults();

        // master abort after 3 active cycles, then a stray late ack
        slv_wait[1] = NEVER;
        cyc = 1'b1; stb = 1'b1; adr = 30'h140;
        tick(); tick(); tick();
        chk("abort_stb_pre", slv_stb, 4'b0010);
        cyc = 1'b0; stb = 1'b0;
        tick();
        chk("abort_stb", slv_stb, 4'h0);
        chk("abort_resp", {ack_o, err_o}, 2'b00);
        late_ack = 4'b0010;
        tick();
        late_ack = 4'h0;
        chk("late_ack_a", {ack_o, err_o}, 2'b00);
        tick();
        chk("late_ack_b", {ack_o, err_o, slv_stb}, 6'h0);
        slv_wait[1] = 2; slv_data[1] = 32'hCAFE_F00D;
        run_req(30'h1AB);

        // fault arriving together with clear is recorded
        run_req(30'h3F0_0001);
        a = 30'h2AA_0000;
        cyc = 1'b1; stb = 1'b1; adr = a; fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0; cyc = 1'b0; stb = 1'b0;
        chk("setclr_err", err_o, 1'b1);
        chk("setclr_fv", fault_valid, 1'b1);
        chk("setclr_adr", fault_adr, a);
        mf_valid = 1'b1; mf_adr = a; mf_type = 1'b0;
        tick();

        // randomized transactions
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < 4; i++) begin
                slv_wait[i] = $urandom_range(0, 20);
                slv_data[i] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) a = 30'($urandom);
            else a = {20'h0, 2'($urandom_range(0, 3)), 8'($urandom)};
            if ($urandom_range(0, 4) == 0) clear_faults();
            run_req(a);
        end

        // asynchronous reset in the middle of an active cycle
        run_req(30'h3F0_0002);
        slv_wait[3] = NEVER;
        cyc = 1'b1; stb = 1'b1; adr = 30'h377;
        tick(); tick();
        chk("pre_rst_stb", slv_stb, 4'b1000);
        #2 rst = 1'b0;
        #1;
        chk("arst_stb", slv_stb, 4'h0);
        chk("arst_resp", {ack_o, err_o}, 2'b00);
        chk("arst_fv", fault_valid, 1'b0);
        chk("arst_fadr", fault_adr, 30'h0);
        mf_valid = 1'b0;
        cyc = 1'b0; stb = 1'b0;
        #3 rst = 1'b1;
        tick();
        slv_wait[3] = 1; slv_data[3] = 32'h0BAD_CAFE;
        run_req(30'h3C1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
